// File: rtl/exu_pkg.sv
// Shared definitions for the execute-stage ALU sequencer:
// FSM state encoding, ALU opcode constants and datapath widths.
package exu_pkg;

   localparam int RESULT_W = 32;
   localparam int OP_W     = 5;
   localparam int WCNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } exu_state_t;

   localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
   localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
   localparam logic [OP_W-1:0] OP_AND = 5'b00010;
   localparam logic [OP_W-1:0] OP_OR  = 5'b00011;
   localparam logic [OP_W-1:0] OP_XOR = 5'b00100;
   localparam logic [OP_W-1:0] OP_SLL = 5'b00101;
   localparam logic [OP_W-1:0] OP_SLT = 5'b00110;
   localparam logic [OP_W-1:0] OP_BEQ = 5'b01101;
   localparam logic [OP_W-1:0] OP_BNE = 5'b01110;
   localparam logic [OP_W-1:0] OP_BLT = 5'b01111;

endpackage

// File: rtl/exu_perf_cnt.sv
// Performance counters for the execute sequencer: completed ops and
// output-stall cycles. Both wrap naturally and clear on reset.
// The whole module only exists when EXU_PERF_CNT_EN is defined, so a
// default build carries no unused counter module at all.
`ifdef EXU_PERF_CNT_EN
module exu_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc_ops,
   input  logic             i_inc_stall,
   output logic [CNT_W-1:0] o_ops,
   output logic [CNT_W-1:0] o_stall
);

   logic [CNT_W-1:0] r_ops;
   logic [CNT_W-1:0] r_stall;

   // count accepted results and backpressured cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ops   <= '0;
         r_stall <= '0;
      end else begin
         if (i_inc_ops)   r_ops   <= r_ops + CNT_W'(1);
         if (i_inc_stall) r_stall <= r_stall + CNT_W'(1);
      end
   end

   assign o_ops   = r_ops;
   assign o_stall = r_stall;

endmodule
`endif

// File: rtl/exu_alu_seq.sv
// Execute-stage sequencer owning the shared ALU. Accepts one op from IDU,
// holds operands to the ALU, pulses start, waits for done (or aborts after
// TIMEOUT wait cycles) and presents the result to WBU. One op in flight.
// Optional feature: EXU_PERF_CNT_EN adds op/stall performance counters;
// without it the perf ports are tied to zero.
//
// state | meaning
// IDLE  | ready for a new op; operands keep last latched values
// ISSUE | single-cycle ALU start pulse, wait counter cleared
// WAIT  | waiting for alu_done or timeout
// DONE  | result presented to WBU until accepted
import exu_pkg::*;

module exu_alu_seq #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [31:0]      in_src1,
   input  logic [31:0]      in_src2,
   input  logic [31:0]      in_csr,
   input  logic [4:0]       in_op,
   input  logic             in_is_branch,
   output logic             alu_start,
   output logic [31:0]      alu_inst,
   output logic [31:0]      alu_src1,
   output logic [31:0]      alu_src2,
   output logic [31:0]      alu_csr,
   output logic [4:0]       alu_op,
   input  logic [31:0]      alu_result,
   input  logic             alu_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_br_taken,
   output logic             out_err,
   output logic [CNT_W-1:0] perf_ops,
   output logic [CNT_W-1:0] perf_stall
);

   localparam logic [WCNT_W-1:0] TO_LAST = WCNT_W'(TIMEOUT - 1);

   exu_state_t            r_state;
   exu_state_t            w_state_nxt;
   logic [31:0]           r_inst;
   logic [31:0]           r_src1;
   logic [31:0]           r_src2;
   logic [31:0]           r_csr;
   logic [OP_W-1:0]       r_op;
   logic                  r_is_br;
   logic [WCNT_W-1:0]     r_wait_cnt;
   logic [RESULT_W-1:0]   r_result;
   logic                  r_br_taken;
   logic                  r_err;
   logic                  w_accept;
   logic                  w_timeout;
   logic                  w_in_ready;
   logic                  w_alu_start;
   logic                  w_out_valid;

   assign w_timeout = (r_wait_cnt == TO_LAST);

   // next-state and state-decoded handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_alu_start = 1'b0;
      w_out_valid = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            w_alu_start = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (alu_done || w_timeout) w_state_nxt = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // operand latch; held through the op and into IDLE until the next accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inst  <= '0;
         r_src1  <= '0;
         r_src2  <= '0;
         r_csr   <= '0;
         r_op    <= '0;
         r_is_br <= 1'b0;
      end else if (w_accept) begin
         r_inst  <= in_inst;
         r_src1  <= in_src1;
         r_src2  <= in_src2;
         r_csr   <= in_csr;
         r_op    <= in_op;
         r_is_br <= in_is_branch;
      end
   end

   // wait-cycle counter; stops at the timeout compare value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (r_state == ISSUE) begin
         r_wait_cnt <= '0;
      end else if (r_state == WAIT && !alu_done && !w_timeout) begin
         r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      end
   end

   // result capture; alu_done takes priority over a simultaneous timeout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result   <= '0;
         r_br_taken <= 1'b0;
         r_err      <= 1'b0;
      end else if (r_state == WAIT) begin
         if (alu_done) begin
            r_result   <= alu_result;
            r_br_taken <= r_is_br & alu_result[0];
            r_err      <= 1'b0;
         end else if (w_timeout) begin
            r_result   <= '0;
            r_br_taken <= 1'b0;
            r_err      <= 1'b1;
         end
      end
   end

   assign in_ready     = w_in_ready;
   assign alu_start    = w_alu_start;
   assign out_valid    = w_out_valid;
   assign alu_inst     = r_inst;
   assign alu_src1     = r_src1;
   assign alu_src2     = r_src2;
   assign alu_csr      = r_csr;
   assign alu_op       = r_op;
   assign out_result   = r_result;
   assign out_br_taken = r_br_taken;
   assign out_err      = r_err;

`ifdef EXU_PERF_CNT_EN
   exu_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_inc_ops   (w_out_valid & out_ready),
      .i_inc_stall (w_out_valid & ~out_ready),
      .o_ops       (perf_ops),
      .o_stall     (perf_stall)
   );
`else
   assign perf_ops   = '0;
   assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_exu_alu_seq.sv
// Scoreboard bench for exu_alu_seq: the driver issues ops and plays the ALU,
// pushing the expected WBU response; a monitor pops and compares on every
// WBU handshake and tracks the performance counters.
import exu_pkg::*;

module tb_exu_alu_seq;

   localparam int TO = 16;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_inst = '0;
   logic [31:0]   in_src1 = '0;
   logic [31:0]   in_src2 = '0;
   logic [31:0]   in_csr = '0;
   logic [4:0]    in_op = '0;
   logic          in_is_branch = 1'b0;
   logic          alu_start;
   logic [31:0]   alu_inst;
   logic [31:0]   alu_src1;
   logic [31:0]   alu_src2;
   logic [31:0]   alu_csr;
   logic [4:0]    alu_op;
   logic [31:0]   alu_result = '0;
   logic          alu_done = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_result;
   logic          out_br_taken;
   logic          out_err;
   logic [CW-1:0] perf_ops;
   logic [CW-1:0] perf_stall;

   always #5 clk = ~clk;

   exu_alu_seq #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_inst      (in_inst),
      .in_src1      (in_src1),
      .in_src2      (in_src2),
      .in_csr       (in_csr),
      .in_op        (in_op),
      .in_is_branch (in_is_branch),
      .alu_start    (alu_start),
      .alu_inst     (alu_inst),
      .alu_src1     (alu_src1),
      .alu_src2     (alu_src2),
      .alu_csr      (alu_csr),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_done     (alu_done),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_br_taken (out_br_taken),
      .out_err      (out_err),
      .perf_ops     (perf_ops),
      .perf_stall   (perf_stall)
   );

   typedef struct packed {
      logic [31:0] res;
      logic        br;
      logic        err;
   } exp_t;

   exp_t          q_exp[$];
   int            errors = 0;
   int            checks = 0;
   logic [CW-1:0] m_ops = '0;
   logic [CW-1:0] m_stall = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_BEQ:  return (a == b) ? 32'd1 : 32'd0;
         OP_BNE:  return (a != b) ? 32'd1 : 32'd0;
         OP_BLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [CW-1:0] exp_perf(input logic [CW-1:0] v);
`ifdef EXU_PERF_CNT_EN
      return v;
`else
      return '0 & v;
`endif
   endfunction

   // monitor: samples just after the falling edge, compares on each WBU handshake
   initial begin
      exp_t prev;
      exp_t e;
      logic held;
      held = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            q_exp.delete();
            m_ops   = '0;
            m_stall = '0;
            held    = 1'b0;
         end else if (out_valid) begin
            check("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
            if (held) begin
               check("stall_result_stable", out_result, prev.res);
               check("stall_br_stable", {31'd0, out_br_taken}, {31'd0, prev.br});
               check("stall_err_stable", {31'd0, out_err}, {31'd0, prev.err});
            end
            if (out_ready) begin
               check("perf_ops", perf_ops, exp_perf(m_ops));
               check("perf_stall", perf_stall, exp_perf(m_stall));
               if (q_exp.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: result 0x%08h with empty scoreboard", out_result);
               end else begin
                  e = q_exp.pop_front();
                  check("out_result", out_result, e.res);
                  check("out_br_taken", {31'd0, out_br_taken}, {31'd0, e.br});
                  check("out_err", {31'd0, out_err}, {31'd0, e.err});
               end
               m_ops = m_ops + 1'b1;
               held  = 1'b0;
            end else begin
               m_stall = m_stall + 1'b1;
               held    = 1'b1;
               prev    = '{out_result, out_br_taken, out_err};
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   // issue one op; d = cycles after start until alu_done (0 = never),
   // stall = cycles WBU holds out_ready low once the result is valid
   task automatic run_op(input logic [4:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic isbr, input int d, input int stall);
      logic [31:0] inst;
      logic [31:0] csr;
      logic [31:0] r;
      exp_t        e;
      int          c;
      int          first_c;
      int          exp_c;
      int          stl;
      int          guard;
      bit          acc;
      bit          ok;
      inst = $urandom;
      csr  = $urandom;
      r    = alu_ref(op, s1, s2);
      ok   = (d >= 1) && (d <= TO);
      e    = ok ? exp_t'{r, isbr & r[0], 1'b0} : exp_t'{32'd0, 1'b0, 1'b1};
      q_exp.push_back(e);
      @(negedge clk);
      out_ready    = 1'b0;
      alu_done     = 1'b0;
      in_valid     = 1'b1;
      in_inst      = inst;
      in_src1      = s1;
      in_src2      = s2;
      in_csr       = csr;
      in_op        = op;
      in_is_branch = isbr;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: in_ready stuck at 0 expected 1");
      end
      @(negedge clk);
      in_valid     = 1'b0;
      in_inst      = $urandom;
      in_src1      = $urandom;
      in_src2      = $urandom;
      in_csr       = $urandom;
      in_op        = 5'($urandom);
      in_is_branch = ~isbr;
      check("alu_start", {31'd0, alu_start}, 32'd1);
      check("alu_inst", alu_inst, inst);
      check("alu_csr", alu_csr, csr);
      check("alu_op", {27'd0, alu_op}, {27'd0, op});
      c = 0;
      acc = 1'b0;
      first_c = -1;
      stl = stall;
      while (!(acc && c >= d) && c < 64) begin
         @(negedge clk);
         c++;
         out_ready = 1'b0;
         alu_done  = 1'b0;
         if (c == 1) check("alu_start_pulse", {31'd0, alu_start}, 32'd0);
         if (d != 0 && c == d) begin
            alu_done   = 1'b1;
            alu_result = alu_ref(alu_op, alu_src1, alu_src2);
         end else begin
            alu_result = $urandom;
         end
         if (!acc && out_valid) begin
            if (first_c < 0) first_c = c;
            if (stl > 0) stl--;
            else begin
               out_ready = 1'b1;
               acc = 1'b1;
            end
         end
      end
      if (c >= 64) begin
         checks++;
         errors++;
         $display("FAIL op_timeout: no result after %0d cycles, expected within %0d", c, TO + 2);
      end
      @(negedge clk);
      out_ready = 1'b0;
      alu_done  = 1'b0;
      check("out_valid_drop", {31'd0, out_valid}, 32'd0);
      exp_c = ok ? d + 1 : TO + 1;
      check("latency", 32'(first_c), 32'(exp_c));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]    ops[10];
      logic [CW-1:0] st0;
      int            sel;
      int            d;
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLT, OP_BEQ, OP_BNE, OP_BLT};

      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_alu_start", {31'd0, alu_start}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      check("rst_alu_src1", alu_src1, 32'd0);
      check("rst_perf_ops", perf_ops, 32'd0);
      rst_n = 1'b1;

      run_op(OP_ADD, 32'd5, 32'd7, 1'b0, 1, 0);
      run_op(OP_BEQ, 32'd9, 32'd9, 1'b1, 1, 0);
      run_op(OP_BEQ, 32'd9, 32'd9, 1'b0, 2, 0);
      run_op(OP_BNE, 32'd3, 32'd3, 1'b1, 1, 0);
      st0 = perf_stall;
      run_op(OP_SUB, 32'd100, 32'd1, 1'b0, 2, 5);
      check("backpressure_stall_delta", perf_stall - st0, exp_perf(32'd5));
      run_op(OP_ADD, 32'd1, 32'd2, 1'b0, 0, 0);
      run_op(OP_XOR, 32'hF0F0_1234, 32'h0FF0_4321, 1'b0, TO, 0);
      run_op(OP_AND, 32'hFFFF_0000, 32'h1234_5678, 1'b1, TO + 1, 1);

      @(negedge clk);
      alu_done   = 1'b1;
      alu_result = 32'hDEAD_BEEF;
      @(negedge clk);
      alu_done = 1'b0;
      check("idle_done_no_valid", {31'd0, out_valid}, 32'd0);
      check("idle_done_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check("idle_done_no_valid2", {31'd0, out_valid}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 5)      d = $urandom_range(1, 3);
         else if (sel <= 7) d = $urandom_range(4, TO);
         else if (sel == 8) d = 0;
         else               d = $urandom_range(TO + 1, TO + 2);
         run_op(ops[$urandom_range(0, 9)], $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                1'($urandom), d, $urandom_range(0, 3));
      end

      @(negedge clk);
      in_valid = 1'b1;
      in_src1  = 32'd11;
      in_src2  = 32'd22;
      in_op    = OP_ADD;
      @(negedge clk);
      in_valid = 1'b0;
      check("rst_test_started", {31'd0, alu_start}, 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midop_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midop_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midop_rst_alu_start", {31'd0, alu_start}, 32'd0);
      check("midop_rst_perf_ops", perf_ops, 32'd0);
      check("midop_rst_perf_stall", perf_stall, 32'd0);
      repeat (TO + 4) @(negedge clk);
      check("midop_rst_no_valid_later", {31'd0, out_valid}, 32'd0);

      run_op(OP_ADD, 32'd5, 32'd7, 1'b0, 1, 0);
      @(negedge clk);
      check("queue_drained", 32'(q_exp.size()), 32'd0);
      check("final_perf_ops", perf_ops, exp_perf(m_ops));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
